// File: rtl/lfsr_8bit_checker.sv
// Sequence checker for the x^8+x^6+x^5+x+1 (internal-XOR) test pattern: hunts for a
// seed, verifies LOCK_COUNT predictions, then flywheels the predictor and counts mismatches.
module lfsr_8bit_checker #(
    parameter int LOCK_COUNT  = 4,
    parameter int LOSS_THRESH = 3,
    parameter int CNT_W       = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [7:0]       data_in,
    input  logic             data_valid,
    input  logic             clear_count,
    output logic             locked,
    output logic             error,
    output logic [CNT_W-1:0] error_count,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_t;

    localparam logic [3:0]       LOCK_C  = 4'(LOCK_COUNT);
    localparam logic [3:0]       LOSS_C  = 4'(LOSS_THRESH);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t     state_r;
    logic [7:0] expected_r;
    logic [3:0] match_cnt_r;
    logic [3:0] miss_cnt_r;
    logic       match_s;
    logic       count_inc_s;

    function automatic logic [7:0] next_word(input logic [7:0] s);
        return {s[0], s[7], s[6] ^ s[0], s[5] ^ s[0], s[4], s[3], s[2], s[1] ^ s[0]};
    endfunction

    assign state = state_r;

    // Word comparison and counter increment request (only mismatches while locked count).
    always_comb begin
        match_s = (data_in == expected_r);
        if (data_valid && (state_r == LOCKED) && !match_s) begin
            count_inc_s = 1'b1;
        end else begin
            count_inc_s = 1'b0;
        end
    end

    // Lock FSM with predictor, run-length counters and registered status outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r     <= HUNT;
            expected_r  <= 8'h00;
            match_cnt_r <= 4'd0;
            miss_cnt_r  <= 4'd0;
            locked      <= 1'b0;
            error       <= 1'b0;
        end else begin
            error <= 1'b0;
            if (data_valid) begin
                case (state_r)
                    HUNT: begin
                        // 0x00 is the lock-up word and can never seed a valid sequence.
                        if (data_in != 8'h00) begin
                            expected_r  <= next_word(data_in);
                            match_cnt_r <= 4'd0;
                            state_r     <= VERIFY;
                        end
                    end
                    VERIFY: begin
                        if (match_s) begin
                            expected_r  <= next_word(data_in);
                            match_cnt_r <= match_cnt_r + 4'd1;
                            if ((match_cnt_r + 4'd1) == LOCK_C) begin
                                state_r    <= LOCKED;
                                miss_cnt_r <= 4'd0;
                                locked     <= 1'b1;
                            end
                        end else if (data_in != 8'h00) begin
                            expected_r  <= next_word(data_in);
                            match_cnt_r <= 4'd0;
                        end else begin
                            state_r <= HUNT;
                        end
                    end
                    LOCKED: begin
                        // Flywheel: prediction advances regardless of what arrived.
                        expected_r <= next_word(expected_r);
                        if (match_s) begin
                            miss_cnt_r <= 4'd0;
                        end else begin
                            error      <= 1'b1;
                            miss_cnt_r <= miss_cnt_r + 4'd1;
                            if ((miss_cnt_r + 4'd1) == LOSS_C) begin
                                state_r <= HUNT;
                                locked  <= 1'b0;
                            end
                        end
                    end
                    default: begin
                        state_r <= HUNT;
                        locked  <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Saturating mismatch counter; a coincident clear takes priority over an increment.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            error_count <= {CNT_W{1'b0}};
        end else if (clear_count) begin
            error_count <= {CNT_W{1'b0}};
        end else if (count_inc_s && (error_count != CNT_MAX)) begin
            error_count <= error_count + CNT_ONE;
        end else begin
            error_count <= error_count;
        end
    end

endmodule

// File: tb/tb_lfsr_8bit_checker.sv
// Directed bench for lfsr_8bit_checker: two instances (default and CNT_W=4/LOSS_THRESH=15)
// share one stimulus stream and are compared every cycle against a table-driven model.
module tb_lfsr_8bit_checker;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  data_in = 8'h00;
    logic        data_valid = 1'b0;
    logic        clear_count = 1'b0;

    logic        d0_locked, d0_error, d1_locked, d1_error;
    logic [15:0] d0_count;
    logic [3:0]  d1_count;
    logic [1:0]  d0_state, d1_state;

    int checks = 0;
    int errors = 0;

    // Sequence table (index -> word) and its inverse, built by stepping the Galois form.
    int seq[255];
    int pos[256];
    int g = 0;

    // Model of each instance: 0=HUNT, 1=VERIFY, 2=LOCKED.
    int m_state[2] = '{0, 0};
    int m_exp[2]   = '{0, 0};
    int m_match[2] = '{0, 0};
    int m_miss[2]  = '{0, 0};
    int m_cnt[2]   = '{0, 0};
    int m_err[2]   = '{0, 0};
    int p_lock[2]  = '{4, 4};
    int p_loss[2]  = '{3, 15};
    int p_max[2]   = '{65535, 15};

    lfsr_8bit_checker u_dut0 (
        .clock(clock), .reset(reset), .data_in(data_in), .data_valid(data_valid),
        .clear_count(clear_count), .locked(d0_locked), .error(d0_error),
        .error_count(d0_count), .state(d0_state)
    );

    lfsr_8bit_checker #(.LOCK_COUNT(4), .LOSS_THRESH(15), .CNT_W(4)) u_dut1 (
        .clock(clock), .reset(reset), .data_in(data_in), .data_valid(data_valid),
        .clear_count(clear_count), .locked(d1_locked), .error(d1_error),
        .error_count(d1_count), .state(d1_state)
    );

    always #5 clock = ~clock;

    task automatic chk(input string nm, input int act, input int exp);
        checks = checks + 1;
        if (act != exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", nm, act, act, exp, exp, $time);
        end
    endtask

    function automatic int nx(input int w);
        return seq[(pos[w] + 1) % 255];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_state[i] = 0; m_exp[i] = 0; m_match[i] = 0;
            m_miss[i] = 0; m_cnt[i] = 0; m_err[i] = 0;
        end
    endtask

    task automatic model_step(input int i, input int v, input int d, input int c);
        int inc;
        inc = 0;
        m_err[i] = 0;
        if (v != 0) begin
            if (m_state[i] == 0) begin
                if (d != 0) begin
                    m_exp[i] = nx(d); m_match[i] = 0; m_state[i] = 1;
                end
            end else if (m_state[i] == 1) begin
                if (d == m_exp[i]) begin
                    m_exp[i] = nx(d);
                    m_match[i] = m_match[i] + 1;
                    if (m_match[i] == p_lock[i]) begin
                        m_state[i] = 2; m_miss[i] = 0;
                    end
                end else if (d != 0) begin
                    m_exp[i] = nx(d); m_match[i] = 0;
                end else begin
                    m_state[i] = 0;
                end
            end else begin
                if (d == m_exp[i]) begin
                    m_miss[i] = 0;
                end else begin
                    inc = 1; m_err[i] = 1;
                    m_miss[i] = m_miss[i] + 1;
                    if (m_miss[i] == p_loss[i]) m_state[i] = 0;
                end
                m_exp[i] = nx(m_exp[i]);
            end
        end
        if (c != 0) m_cnt[i] = 0;
        else if (inc != 0 && m_cnt[i] < p_max[i]) m_cnt[i] = m_cnt[i] + 1;
    endtask

    task automatic cycle(input logic v, input logic [7:0] d, input logic c);
        data_valid  = v;
        data_in     = d;
        clear_count = c;
        @(posedge clock);
        for (int i = 0; i < 2; i++) model_step(i, int'(v), int'(d), int'(c));
        #1;
    endtask

    task automatic send_good(input int n);
        for (int k = 0; k < n; k++) begin
            cycle(1'b1, 8'(seq[g % 255]), 1'b0);
            g = g + 1;
        end
    endtask

    task automatic send_bad(input logic c);
        cycle(1'b1, 8'(seq[g % 255] ^ 1), c);
        g = g + 1;
    endtask

    // Per-cycle comparison of both instances against the model, away from the active edge.
    always @(negedge clock) begin
        chk("d0_locked", int'(d0_locked), int'(m_state[0] == 2));
        chk("d0_error",  int'(d0_error),  m_err[0]);
        chk("d0_count",  int'(d0_count),  m_cnt[0]);
        chk("d0_state",  int'(d0_state),  m_state[0]);
        chk("d1_locked", int'(d1_locked), int'(m_state[1] == 2));
        chk("d1_error",  int'(d1_error),  m_err[1]);
        chk("d1_count",  int'(d1_count),  m_cnt[1]);
        chk("d1_state",  int'(d1_state),  m_state[1]);
    end

    initial begin
        int s;
        int bad;
        for (int k = 0; k < 256; k++) pos[k] = -1;
        s = 1;
        for (int k = 0; k < 255; k++) begin
            seq[k] = s;
            pos[s] = k;
            s = (s >> 1) ^ (((s & 1) != 0) ? 'hB1 : 0);
        end
        chk("tbl_period", s, 1);
        chk("tbl_word1", seq[1], 'hB1);
        chk("tbl_word2", seq[2], 'hE9);

        // Reset state
        repeat (2) @(posedge clock);
        #1;
        chk("rst_state", int'(d0_state), 0);
        chk("rst_locked", int'(d0_locked), 0);
        chk("rst_count", int'(d0_count), 0);
        chk("rst_count1", int'(d1_count), 0);
        reset = 1'b1;

        // Lock acquisition
        send_good(1);
        chk("acq_verify", int'(d0_state), 1);
        send_good(3);
        chk("acq_not_yet", int'(d0_locked), 0);
        send_good(1);
        chk("acq_locked0", int'(d0_locked), 1);
        chk("acq_locked1", int'(d1_locked), 1);
        chk("acq_count", int'(d0_count), 0);

        // Single bit error
        send_bad(1'b0);
        chk("sbe_error", int'(d0_error), 1);
        chk("sbe_count", int'(d0_count), 1);
        chk("sbe_locked", int'(d0_locked), 1);
        send_good(1);
        chk("sbe_recover", int'(d0_error), 0);
        chk("sbe_count_hold", int'(d0_count), 1);

        // Gaps in a locked stream
        for (int k = 0; k < 4; k++) begin
            cycle(1'b0, 8'h00, 1'b0);
            send_good(1);
            cycle(1'b0, 8'h5A, 1'b0);
        end
        chk("gap_count", int'(d0_count), 1);
        chk("gap_locked", int'(d0_locked), 1);

        // Loss of lock after clearing the count
        cycle(1'b0, 8'h00, 1'b1);
        chk("clr_count", int'(d0_count), 0);
        chk("clr_keeps_lock", int'(d0_locked), 1);
        send_bad(1'b0);
        send_bad(1'b0);
        chk("loss_still_locked", int'(d0_locked), 1);
        send_bad(1'b0);
        chk("loss_error3", int'(d0_error), 1);
        chk("loss_locked", int'(d0_locked), 0);
        chk("loss_state", int'(d0_state), 0);
        chk("loss_count", int'(d0_count), 3);
        chk("loss_d1_locked", int'(d1_locked), 1);
        send_good(4);
        chk("relock_not_yet", int'(d0_locked), 0);
        send_good(1);
        chk("relock", int'(d0_locked), 1);

        // Clear concurrent with a mismatch
        send_bad(1'b1);
        chk("clrmis_error", int'(d0_error), 1);
        chk("clrmis_count", int'(d0_count), 0);
        send_good(2);

        // Asynchronous reset mid-lock
        reset = 1'b0;
        model_reset();
        #1;
        chk("arst_locked", int'(d0_locked), 0);
        chk("arst_count", int'(d0_count), 0);
        chk("arst_state", int'(d0_state), 0);
        @(posedge clock);
        #1;
        reset = 1'b1;

        // Zero words in HUNT, reseed and zero exit in VERIFY
        for (int k = 0; k < 3; k++) cycle(1'b1, 8'h00, 1'b0);
        chk("zero_hunt", int'(d0_state), 0);
        bad = (nx(seq[g % 255]) == 'h55) ? 'hAA : 'h55;
        send_good(1);
        chk("seed_verify", int'(d0_state), 1);
        cycle(1'b1, 8'(bad), 1'b0);
        chk("reseed_state", int'(d0_state), 1);
        chk("reseed_error", int'(d0_error), 0);
        chk("reseed_count", int'(d0_count), 0);
        cycle(1'b1, 8'h00, 1'b0);
        chk("verify_zero_hunt", int'(d0_state), 0);

        // Saturation of the narrow counter
        send_good(5);
        chk("sat_locked0", int'(d0_locked), 1);
        chk("sat_locked1", int'(d1_locked), 1);
        for (int k = 0; k < 20; k++) begin
            send_bad(1'b0);
            send_good(1);
        end
        chk("sat_count1", int'(d1_count), 15);
        chk("sat_count0", int'(d0_count), 20);
        chk("sat_locked1_hold", int'(d1_locked), 1);
        chk("sat_locked0_hold", int'(d0_locked), 1);

        cycle(1'b0, 8'h00, 1'b0);
        cycle(1'b0, 8'h00, 1'b0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lfsr_8bit_checker.md
# lfsr_8bit_checker

Receive-side sequence checker for the 8-bit pseudo-random test pattern (polynomial x^8+x^6+x^5+x+1, internal-XOR form) produced by the on-chip pattern generator. It sits directly downstream of the generator, usually across the link or datapath under test. It synchronises a local predictor to the incoming stream, declares lock, and then counts mismatching words. It reports lock status, a per-word error pulse and a saturating error count to the BIST controller.

## Interface
- LOCK_COUNT, 4: consecutive matching words needed in VERIFY to declare lock; legal range 1..15.
- LOSS_THRESH, 3: consecutive mismatches in LOCKED that drop lock; legal range 1..15.
- CNT_W, 16: width of error_count.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low; all state to reset values.
- data_in  input  8  received pattern word.
- data_valid  input  1  data_in is a new, consecutive sequence word this cycle.
- clear_count  input  1  synchronous; zero error_count.
- locked  output  1  predictor synchronised.
- error  output  1  one-cycle pulse: previous valid word mismatched while LOCKED.
- error_count  output  CNT_W  saturating mismatch count.
- state  output  2  FSM state: HUNT=0, VERIFY=1, LOCKED=2.

## Operation
- Next-state function N(s) for an 8-bit word s: {s[0], s[7], s[6]^s[0], s[5]^s[0], s[4], s[3], s[2], s[1]^s[0]}. The sequence period is 255, and 0x00 is the lock-up word.
- Internal registers: expected[7:0], match_cnt (4 bits), miss_cnt (4 bits).
- All actions below happen only on cycles with data_valid=1. On cycles with data_valid=0, every register holds and error=0.
- HUNT:
  - data_in==0x00: ignored; stay in HUNT.
  - Otherwise: expected<=N(data_in), match_cnt<=0, go to VERIFY.
- VERIFY, data_in==expected:
  - expected<=N(data_in), match_cnt<=match_cnt+1.
  - If match_cnt+1==LOCK_COUNT: go to LOCKED, miss_cnt<=0.
- VERIFY, mismatch:
  - data_in!=0x00: reseed with expected<=N(data_in), match_cnt<=0, stay in VERIFY.
  - data_in==0x00: go to HUNT.
- VERIFY never asserts error and never increments the count.
- LOCKED (flywheel): expected<=N(expected) on every valid word, independent of data_in.
  - Match: miss_cnt<=0.
  - Mismatch: error pulses, error_count increments, miss_cnt<=miss_cnt+1.
  - If miss_cnt+1==LOSS_THRESH: go to HUNT. The error for that word is still reported.
- error_count saturates at all-ones with no wrap.
- clear_count zeroes the count. If clear_count coincides with an increment, clear wins and the count is 0.
- clear_count does not affect FSM state or lock.

## Timing
- Reset values: locked=0, error=0, error_count=0, state=HUNT, expected=0x00, match_cnt=0, miss_cnt=0.
- All outputs are registered and update at the clock edge that samples the qualifying data_valid word.
- Lock latency: locked rises at the edge sampling the (LOCK_COUNT+1)-th consecutive valid word, counting the seed word.
- Error pulse: error is high for exactly the one cycle following the mismatching word's sampling edge. error_count updates at the same edge.
- Back-to-back mismatches give consecutive error pulses.
- Loss of lock: locked falls at the edge that samples the LOSS_THRESH-th consecutive mismatch.
- Reset asserted mid-operation clears everything immediately. After release, the checker hunts again.
- data_valid gaps do not disturb the prediction. The upstream side must present consecutive sequence words on consecutive valid cycles.

## Test plan
- Lock acquisition, defaults: reset, then drive 0x01, 0xB1, 0xE9 and onward from N(), one word per cycle. Required: state 0→1 after 0x01, locked=1 after the 5th word, error never asserted, error_count=0.
- Single bit error: once locked, corrupt one word (flip bit 0). Required: one error pulse on the following cycle, error_count=1, locked stays 1, and the next correct word matches with no further error.
- Loss of lock: once locked, send 3 consecutive wrong words. Required: 3 error pulses, error_count=3, locked falls on the 3rd, state=HUNT. A correct stream then relocks after 5 words.
- Zero and VERIFY reseed: in HUNT drive 0x00 ×3, then state stays HUNT. In VERIFY, a wrong nonzero word reseeds with no error and count 0; a 0x00 word returns to HUNT.
- Gaps and saturation: interleave data_valid=0 cycles in a locked stream, and there are no errors. Set CNT_W=4 and force 20 errors, with LOSS_THRESH=15 and correct words interleaved; error_count holds at 15.
- Clear and reset: clear_count concurrent with a mismatch gives count 0 while the error pulse still occurs. Async reset mid-lock gives locked=0 and count=0 immediately.
